hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 36 +++
 rtl/hazard_scoreboard.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : IF/ID, write-back and hazard-result signals exchanged between
//               the pipeline control (master) and the hazard scoreboard (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
);
  logic                id_valid;
  logic [3:0]          id_opcode;
  logic [ADDR_W-1:0]   id_rs;
  logic [ADDR_W-1:0]   id_rt;
  logic [ADDR_W-1:0]   id_rd;
  logic                flush;
  logic                wb_RegWrite;
  logic [ADDR_W-1:0]   wb_rd;
  logic                stall;
  logic                bypass_rs;
  logic                bypass_rt;
  logic [NUM_REGS-1:0] busy_vec;
  logic                stall_timeout;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, flush, wb_RegWrite, wb_rd,
    input  stall, bypass_rs, bypass_rt, busy_vec, stall_timeout
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, flush, wb_RegWrite, wb_rd,
    output stall, bypass_rs, bypass_rt, busy_vec, stall_timeout
  );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Per-register latency scoreboard producing the ID-stage stall,
//               write-back bypass selects and a sticky stall-timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = 4,
  parameter int ALU_LAT   = 1,
  parameter int LOAD_LAT  = 2,
  parameter int CNT_W     = 3,
  parameter int MAX_STALL = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave sb
);

  localparam logic [3:0] c_OP_ADD    = 4'd0;
  localparam logic [3:0] c_OP_SUB    = 4'd1;
  localparam logic [3:0] c_OP_XOR    = 4'd2;
  localparam logic [3:0] c_OP_RED    = 4'd3;
  localparam logic [3:0] c_OP_SLL    = 4'd4;
  localparam logic [3:0] c_OP_SRA    = 4'd5;
  localparam logic [3:0] c_OP_ROR    = 4'd6;
  localparam logic [3:0] c_OP_PADDSB = 4'd7;
  localparam logic [3:0] c_OP_LW     = 4'd8;
  localparam logic [3:0] c_OP_SW     = 4'd9;
  localparam logic [3:0] c_OP_LLB    = 4'd10;
  localparam logic [3:0] c_OP_LHB    = 4'd11;
  localparam logic [3:0] c_OP_BR     = 4'd13;
  localparam logic [3:0] c_OP_PCS    = 4'd14;

  localparam logic [CNT_W-1:0] c_ALU_LOAD = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] c_LW_LOAD  = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam int               c_SC_W     = $clog2(MAX_STALL + 1);
  localparam logic [c_SC_W-1:0] c_STALL_MAX = c_SC_W'(MAX_STALL);

  logic [CNT_W-1:0]  cnt_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d [NUM_REGS];
  logic              prev_wr_q, prev_wr_d;
  logic [ADDR_W-1:0] prev_rd_q, prev_rd_d;
  logic [c_SC_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;

  logic              w_uses_rs, w_uses_rt, w_writer, w_is_lw, w_is_sw, w_is_br;
  logic [CNT_W-1:0]  w_cnt_rs, w_cnt_rt, w_cnt_rd, w_load_val;
  logic              w_rs_haz, w_rt_haz, w_br_haz, w_waw_haz;
  logic              w_stall, w_issue, w_load;
  logic [NUM_REGS-1:0] w_busy;

  // Opcode decode: which fields are read, whether a result is written.
  always_comb begin
    w_uses_rs = 1'b0;
    w_uses_rt = 1'b0;
    w_writer  = 1'b0;
    w_is_lw   = 1'b0;
    w_is_sw   = 1'b0;
    w_is_br   = 1'b0;
    case (sb.id_opcode)
      c_OP_ADD, c_OP_SUB, c_OP_XOR, c_OP_RED, c_OP_PADDSB: begin
        w_uses_rs = 1'b1;
        w_uses_rt = 1'b1;
        w_writer  = 1'b1;
      end
      c_OP_SLL, c_OP_SRA, c_OP_ROR, c_OP_LLB, c_OP_LHB: begin
        w_uses_rs = 1'b1;
        w_writer  = 1'b1;
      end
      c_OP_LW: begin
        w_uses_rs = 1'b1;
        w_writer  = 1'b1;
        w_is_lw   = 1'b1;
      end
      c_OP_SW: begin
        w_uses_rs = 1'b1;
        w_uses_rt = 1'b1;
        w_is_sw   = 1'b1;
      end
      c_OP_BR: begin
        w_uses_rs = 1'b1;
        w_is_br   = 1'b1;
      end
      c_OP_PCS: w_writer = 1'b1;
      default: ;  // B and HLT touch no registers
    endcase
  end

  // Counter lookup; register 0 and out-of-range addresses read as idle.
  always_comb begin
    w_cnt_rs = '0;
    w_cnt_rt = '0;
    w_cnt_rd = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (sb.id_rs == ADDR_W'(r)) w_cnt_rs = cnt_q[r];
      if (sb.id_rt == ADDR_W'(r)) w_cnt_rt = cnt_q[r];
      if (sb.id_rd == ADDR_W'(r)) w_cnt_rd = cnt_q[r];
    end
  end

  assign w_load_val = w_is_lw ? c_LW_LOAD : c_ALU_LOAD;
  assign w_rs_haz   = w_uses_rs && (w_cnt_rs != '0);
  // Store data is forwarded in MEM, so one remaining cycle is tolerable on rt.
  assign w_rt_haz   = w_uses_rt && (w_is_sw ? (w_cnt_rt > c_CNT_ONE) : (w_cnt_rt != '0));
  // Branches resolve in ID, so even a zero-latency producer one cycle ahead blocks them.
  assign w_br_haz   = w_is_br && prev_wr_q && (prev_rd_q == sb.id_rs) && (sb.id_rs != '0);
  assign w_waw_haz  = w_writer && (w_cnt_rd > w_load_val);
  assign w_stall    = rst_n && sb.id_valid && !sb.flush &&
                      (w_rs_haz || w_rt_haz || w_br_haz || w_waw_haz);
  assign w_issue    = sb.id_valid && !sb.flush && !w_stall;
  assign w_load     = w_issue && w_writer && (sb.id_rd != '0);

  assign prev_wr_d = w_load;
  assign prev_rd_d = sb.id_rd;

  // Next counter values: issue load overrides the per-cycle decrement.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - c_CNT_ONE) : '0;
      if (w_load && (sb.id_rd == ADDR_W'(r))) cnt_d[r] = w_load_val;
    end
    cnt_d[0] = '0;
  end

  // Saturating consecutive-stall counter and sticky timeout.
  always_comb begin
    if (!w_stall)                        stall_cnt_d = '0;
    else if (stall_cnt_q == c_STALL_MAX) stall_cnt_d = stall_cnt_q;
    else                                 stall_cnt_d = stall_cnt_q + c_SC_W'(1);
    timeout_d = timeout_q || (stall_cnt_d == c_STALL_MAX);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      prev_wr_q   <= 1'b0;
      prev_rd_q   <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      prev_wr_q   <= prev_wr_d;
      prev_rd_q   <= prev_rd_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Busy view of the scoreboard.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) w_busy[r] = (cnt_q[r] != '0);
  end

  assign sb.busy_vec      = w_busy;
  assign sb.stall         = w_stall;
  assign sb.stall_timeout = timeout_q;
  assign sb.bypass_rs     = rst_n && sb.wb_RegWrite && (sb.wb_rd == sb.id_rs) &&
                            (sb.id_rs != '0) && w_uses_rs;
  assign sb.bypass_rt     = rst_n && sb.wb_RegWrite && (sb.wb_rd == sb.id_rt) &&
                            (sb.id_rt != '0) && w_uses_rt;

endmodule
`default_nettype wire
